// File: rtl/uart_rx_if.sv
// Serial-receive bundle: oversampling tick and line in, received word and status out.
// The master side drives the line and tick; the slave side is the receiver.
interface uart_rx_if #(
    parameter int N_DATA       = 8,
    parameter int PARITY_CHECK = 0
);
    logic                             i_tick;
    logic                             i_rx;
    logic [N_DATA+PARITY_CHECK-1:0]   o_rx_data;
    logic                             o_rx_done;
    logic                             o_parity_err;
    logic                             o_frame_err;

    modport master (
        output i_tick, i_rx,
        input  o_rx_data, o_rx_done, o_parity_err, o_frame_err
    );

    modport slave (
        input  i_tick, i_rx,
        output o_rx_data, o_rx_done, o_parity_err, o_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver with optional even parity and configurable stop length.
// The line is resynchronised, sampled at mid-bit, and the word is published on a done pulse.
module uart_rx #(
    parameter int N_DATA       = 8,
    parameter int PARITY_CHECK = 0,
    parameter int N_STOP_TICKS = 16
) (
    input  logic     i_clk,
    input  logic     i_rst,
    uart_rx_if.slave bus
);
    localparam int              W_OUT     = N_DATA + PARITY_CHECK;
    localparam int              W_BIT     = (N_DATA > 1) ? $clog2(N_DATA) : 1;
    localparam logic [3:0]      STOP_LAST = 4'(N_STOP_TICKS - 1);
    localparam logic [W_BIT-1:0] BIT_LAST = W_BIT'(N_DATA - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_sync;
    logic               w_rx_s;
    logic [3:0]         r_tick_cnt, w_tick_cnt_nxt;
    logic [W_BIT-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [N_DATA-1:0]  r_shift, w_shift_nxt;
    logic               r_par_bit, w_par_bit_nxt;
    logic [W_OUT-1:0]   r_rx_data, w_rx_data_nxt, w_word;
    logic               r_rx_done, w_rx_done_nxt;
    logic               r_parity_err, w_parity_err_nxt;
    logic               r_frame_err, w_frame_err_nxt;

    assign w_rx_s = r_sync[1];

    generate
        if (PARITY_CHECK != 0) begin : g_par_word
            assign w_word = {r_par_bit, r_shift};
        end else begin : g_plain_word
            assign w_word = r_shift;
        end
    endgenerate

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        w_state_nxt      = r_state;
        w_tick_cnt_nxt   = r_tick_cnt;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_par_bit_nxt    = r_par_bit;
        w_rx_data_nxt    = r_rx_data;
        w_parity_err_nxt = r_parity_err;
        w_rx_done_nxt    = 1'b0;
        w_frame_err_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nxt    = S_START;
                    w_tick_cnt_nxt = '0;
                end
            end
            S_START: begin
                if (bus.i_tick) begin
                    if (r_tick_cnt == 4'd7) begin
                        // A line that is high again at mid start bit was only a glitch.
                        w_state_nxt    = w_rx_s ? S_IDLE : S_DATA;
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = '0;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    end
                end
            end
            S_DATA: begin
                if (bus.i_tick) begin
                    if (r_tick_cnt == 4'd15) begin
                        w_shift_nxt    = {w_rx_s, r_shift[N_DATA-1:1]};
                        w_tick_cnt_nxt = '0;
                        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST)
                            w_state_nxt = (PARITY_CHECK != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (bus.i_tick) begin
                    if (r_tick_cnt == 4'd15) begin
                        w_par_bit_nxt  = w_rx_s;
                        w_tick_cnt_nxt = '0;
                        w_state_nxt    = S_STOP;
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (bus.i_tick) begin
                    if (r_tick_cnt == STOP_LAST) begin
                        w_state_nxt    = S_IDLE;
                        w_tick_cnt_nxt = '0;
                        if (w_rx_s) begin
                            w_rx_done_nxt    = 1'b1;
                            w_rx_data_nxt    = w_word;
                            w_parity_err_nxt = (PARITY_CHECK != 0) ? ((^r_shift) ^ r_par_bit) : 1'b0;
                        end else begin
                            w_frame_err_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 4'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: registers update with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync       <= 2'b11;
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_bit    <= 1'b0;
            r_rx_data    <= '0;
            r_rx_done    <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], bus.i_rx};
            r_state      <= w_state_nxt;
            r_tick_cnt   <= w_tick_cnt_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_par_bit    <= w_par_bit_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_done    <= w_rx_done_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_frame_err  <= w_frame_err_nxt;
        end
    end

    assign bus.o_rx_data    = r_rx_data;
    assign bus.o_rx_done    = r_rx_done;
    assign bus.o_parity_err = r_parity_err;
    assign bus.o_frame_err  = r_frame_err;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: one receiver without parity, one with even parity.
// Frames come from a vector table; a per-receiver scoreboard queue is compared on each output pulse.
`timescale 1ns/1ps
module tb_uart_rx;
    typedef struct packed {
        logic       ferr;
        logic [8:0] data;
        logic       perr;
    } exp_t;

    typedef struct {
        int unsigned dut;
        logic [7:0]  data;
        logic        par_bit;
        logic        stop_bit;
        logic        exp_ferr;
        logic [8:0]  exp_data;
        logic        exp_perr;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;
    logic tick_en = 1'b1;
    logic rx0 = 1'b1;
    logic rx1 = 1'b1;

    int checks = 0;
    int failures = 0;
    int n_evt0 = 0;
    int n_evt1 = 0;
    exp_t q0[$];
    exp_t q1[$];
    vec_t vecs[12];

    uart_rx_if #(.N_DATA(8), .PARITY_CHECK(0)) if0 ();
    uart_rx_if #(.N_DATA(8), .PARITY_CHECK(1)) if1 ();

    assign if0.i_tick = tick;
    assign if0.i_rx   = rx0;
    assign if1.i_tick = tick;
    assign if1.i_rx   = rx1;

    uart_rx #(.N_DATA(8), .PARITY_CHECK(0), .N_STOP_TICKS(16)) dut0 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if0.slave)
    );

    uart_rx #(.N_DATA(8), .PARITY_CHECK(1), .N_STOP_TICKS(16)) dut1 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (if1.slave)
    );

    initial forever #5 clk = ~clk;

    // One-clock tick every 4 clocks, driven away from the sampling edge.
    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            div = (div == 3) ? 0 : div + 1;
            tick = tick_en && (div == 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic score(input int which, input logic done, input logic ferr,
                         input logic [8:0] data, input logic perr);
        exp_t  e;
        string p;
        p = (which == 0) ? "dut0" : "dut1";
        check({p, "_done_ferr_exclusive"}, 32'(done & ferr), 32'd0);
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected_output: got done=%0b ferr=%0b expected none", p, done, ferr);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            check({p, "_frame_err"}, 32'(ferr), 32'(e.ferr));
            check({p, "_rx_data"}, 32'(data), 32'(e.data));
            check({p, "_parity_err"}, 32'(perr), 32'(e.perr));
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (if0.o_rx_done || if0.o_frame_err) begin
            n_evt0++;
            score(0, if0.o_rx_done, if0.o_frame_err, {1'b0, if0.o_rx_data}, if0.o_parity_err);
        end
        if (if1.o_rx_done || if1.o_frame_err) begin
            n_evt1++;
            score(1, if1.o_rx_done, if1.o_frame_err, if1.o_rx_data, if1.o_parity_err);
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (tick !== 1'b1) @(posedge clk);
        end
    endtask

    task automatic drive_bit(input int which, input logic v, input int n);
        @(negedge clk);
        if (which == 0) rx0 = v;
        else            rx1 = v;
        wait_ticks(n);
    endtask

    // A low stop bit is held only briefly so the trailing low cannot pass as a new start bit.
    task automatic send_frame(input int which, input logic [7:0] data, input logic has_par,
                              input logic par_bit, input logic stop_bit);
        drive_bit(which, 1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i], 16);
        if (has_par) drive_bit(which, par_bit, 16);
        if (stop_bit) begin
            drive_bit(which, 1'b1, 16);
        end else begin
            drive_bit(which, 1'b0, 10);
            drive_bit(which, 1'b1, 24);
        end
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 2000 && (q0.size() + q1.size()) != 0; k++) @(negedge clk);
        check("scoreboard_drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    initial begin
        int   snap;
        int   exp_n0;
        int   exp_n1;
        exp_t e;
        logic [7:0] d;

        //         dut data   par   stop  ferr  exp_data perr
        vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 9'h0A5, 1'b0};
        vecs[1]  = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 9'h0A5, 1'b0};
        vecs[2]  = '{0, 8'h00, 1'b0, 1'b1, 1'b0, 9'h000, 1'b0};
        vecs[3]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b0, 9'h0FF, 1'b0};
        vecs[4]  = '{0, 8'h55, 1'b0, 1'b1, 1'b0, 9'h055, 1'b0};
        vecs[5]  = '{1, 8'h07, 1'b1, 1'b1, 1'b0, 9'h107, 1'b0};
        vecs[6]  = '{1, 8'h07, 1'b0, 1'b1, 1'b0, 9'h007, 1'b1};
        vecs[7]  = '{1, 8'hFF, 1'b0, 1'b1, 1'b0, 9'h0FF, 1'b0};
        vecs[8]  = '{1, 8'h01, 1'b0, 1'b1, 1'b0, 9'h001, 1'b1};
        vecs[9]  = '{1, 8'h3C, 1'b0, 1'b0, 1'b1, 9'h001, 1'b1};
        vecs[10] = '{1, 8'h96, 1'b0, 1'b1, 1'b0, 9'h096, 1'b0};
        vecs[11] = '{1, 8'h96, 1'b1, 1'b1, 1'b0, 9'h196, 1'b1};

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_data0", 32'(if0.o_rx_data), 32'd0);
        check("reset_rx_done0", 32'(if0.o_rx_done), 32'd0);
        check("reset_frame_err0", 32'(if0.o_frame_err), 32'd0);
        check("reset_parity_err0", 32'(if0.o_parity_err), 32'd0);
        check("reset_rx_data1", 32'(if1.o_rx_data), 32'd0);
        check("reset_parity_err1", 32'(if1.o_parity_err), 32'd0);
        wait_ticks(20);

        // Frames go out with no idle gap, so 0x00/0xFF/0x55 run back to back.
        exp_n0 = 0;
        exp_n1 = 0;
        foreach (vecs[i]) begin
            e = '{vecs[i].exp_ferr, vecs[i].exp_data, vecs[i].exp_perr};
            if (vecs[i].dut == 0) begin
                q0.push_back(e);
                exp_n0++;
            end else begin
                q1.push_back(e);
                exp_n1++;
            end
            send_frame(int'(vecs[i].dut), vecs[i].data, vecs[i].dut == 1,
                       vecs[i].par_bit, vecs[i].stop_bit);
        end
        wait_drain();

        // Short low pulse must be rejected at mid start bit.
        snap = n_evt0;
        drive_bit(0, 1'b0, 5);
        drive_bit(0, 1'b1, 30);
        check("glitch_no_output", 32'(n_evt0 - snap), 32'd0);

        // Ticks stall mid-frame; the receiver must hold and finish the frame once they resume.
        q0.push_back('{1'b0, 9'h05A, 1'b0});
        exp_n0++;
        fork
            send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
            begin
                wait_ticks(60);
                tick_en = 1'b0;
                repeat (300) @(negedge clk);
                tick_en = 1'b1;
            end
        join
        wait_drain();

        // Reset during the 4th data bit of 0x81 aborts it silently.
        snap = n_evt0;
        d = 8'h81;
        drive_bit(0, 1'b0, 16);
        for (int i = 0; i < 3; i++) drive_bit(0, d[i], 16);
        drive_bit(0, d[3], 8);
        @(negedge clk);
        rst = 1'b1;
        rx0 = 1'b1;
        repeat (3) @(negedge clk);
        check("midreset_rx_data0", 32'(if0.o_rx_data), 32'd0);
        check("midreset_parity_err1", 32'(if1.o_parity_err), 32'd0);
        rst = 1'b0;
        wait_ticks(24);
        check("midreset_no_output", 32'(n_evt0 - snap), 32'd0);
        q0.push_back('{1'b0, 9'h042, 1'b0});
        exp_n0++;
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1);
        wait_drain();

        check("dut0_event_count", 32'(n_evt0), 32'(exp_n0));
        check("dut1_event_count", 32'(n_evt1), 32'(exp_n1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
